icache_fetch_ctrl: RTL and testbench
====================================

Name: icache_fetch_ctrl

Overview:
- Instruction-fetch cache controller. Sits directly upstream of the IF/ID pipeline register.
- Takes the current PC and returns the instruction word, PC+4 and a hit flag. These drive the register's instruction input, adder input and hit input.
- Direct-mapped instruction cache. On a miss, a refill FSM fetches a whole line from instruction memory over a valid-qualified burst interface.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.
- Derived, not overridable: OFF = log2(WORDS), IDX = log2(LINES), TAG = 30 - OFF - IDX (24 at defaults).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- pc  in  32  fetch address; bits [1:0] ignored.
- flush  in  1  synchronous invalidate of all lines.
- instruction  out  32  cached word at pc; 0 when hit=0.
- adder_out  out  32  pc + 4, modulo 2^32; combinational.
- hit  out  1  instruction valid for the current pc.
- mem_req  out  1  refill burst in progress.
- mem_addr  out  32  word address of the current refill beat.
- mem_rdata  in  32  refill data.
- mem_valid  in  1  mem_rdata valid this cycle (one beat).

Behaviour:
- Address split:
  - offset = pc[OFF+1:2]
  - index = pc[OFF+IDX+1:OFF+2]
  - tag = pc[31:OFF+IDX+2]
- Storage:
  - data array LINES x WORDS x 32
  - tag array LINES x TAG
  - valid bit per line
- Reset (rstn low, asynchronous):
  - all valid bits 0; state IDLE; beat counter 0; mem_req 0; mem_addr 0.
  - hit therefore 0 and instruction 0.
  - Data and tag arrays are not reset.
- hit = (state == IDLE) & valid[index] & (tag_array[index] == tag). Combinational, zero-cycle latency.
- instruction = data[index][offset] when hit, else 0.
- IDLE:
  - If !hit and !flush, go to REFILL next cycle.
  - On that transition, latch line_base = {pc[31:OFF+2], OFF+2 zero bits}; beat = 0.
- REFILL:
  - mem_req = 1; mem_addr = line_base + 4*beat.
  - On each mem_valid: write mem_rdata to data[latched index][beat]; beat += 1.
  - mem_valid with mem_req = 0 is ignored.
  - On the beat with beat == WORDS-1 and mem_valid:
    - write the tag; set valid; return to IDLE.
    - mem_req drops the next cycle.
  - Zero-wait memory (mem_valid every cycle): REFILL lasts exactly WORDS cycles. hit for the missed pc rises on the cycle after the last beat.
  - The valid bit of the line being refilled is cleared on REFILL entry. No partial hits.
- pc change during REFILL:
  - The refill completes for the latched line; the new pc is not tracked.
  - Re-evaluated in IDLE; may miss again.
- flush:
  - In IDLE: all valid bits cleared at posedge; no refill starts that cycle.
  - In REFILL: the burst completes, but the line is not marked valid (flush wins); then IDLE with all lines invalid.
- Simultaneous flush and final beat: line stays invalid.
- Reset asserted mid-REFILL:
  - immediate return to IDLE; mem_req 0; all valid bits 0.
  - The memory side must tolerate the abandoned burst.
- Address wrap: adder_out for pc = 0xFFFFFFFC is 0x00000000.
- mem_addr is never beyond the line; beat wraps only through the REFILL exit.

Test Plan:
- Reset, then pc = 0x00000100, zero-wait memory returning 0xA0+beat:
  - hit = 0 at first; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - hit = 1 the cycle after; instruction 0xA0; adder_out 0x104.
- After that fill, pc = 0x108: hit = 1 in the same cycle; instruction 0xA2; no mem_req.
- pc = 0x00000500 (same index as 0x100, different tag) with mem_valid every other cycle:
  - refill takes 8 cycles; the old line is evicted.
  - Returning to pc = 0x100 misses again.
- Assert flush for one cycle while hitting on 0x100: next cycle hit = 0 and a refill starts.
- Drop rstn on the second refill beat:
  - mem_req goes 0 immediately.
  - After release, pc = 0x100 misses and restarts at mem_addr 0x100.
- pc = 0xFFFFFFFC: adder_out = 0x00000000; refill addresses 0xFFFFFFF0 to 0xFFFFFFFC.

Source files
------------

// File: rtl/icache_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_ctrl_if
// Description : Fetch-side and refill-side signal bundle of the instruction
//               cache controller. The master modport is the environment
//               (fetch stage and instruction memory); the slave modport is the
//               cache controller itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_fetch_ctrl_if;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instruction;
    logic [31:0] adder_out;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output pc, flush, mem_rdata, mem_valid,
        input  instruction, adder_out, hit, mem_req, mem_addr
    );

    modport slave (
        input  pc, flush, mem_rdata, mem_valid,
        output instruction, adder_out, hit, mem_req, mem_addr
    );
endinterface
`default_nettype wire

// File: rtl/icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_ctrl
// Description : Direct-mapped instruction cache in front of the IF/ID
//               register. Hit/instruction/pc+4 are combinational; a miss
//               starts a whole-line burst refill from instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    icache_fetch_ctrl_if.slave bus
);
    localparam int OFF = $clog2(WORDS);
    localparam int IDX = $clog2(LINES);
    localparam int TAG = 30 - OFF - IDX;
    localparam int LA  = 30 - OFF;          // width of a line address
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Tag and data storage are deliberately not reset; the valid bits gate them.
    logic [LINES-1:0] valid;
    logic [TAG-1:0]   tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    logic [LA-1:0]    line_addr;            // line being refilled
    logic [OFF-1:0]   beat;
    logic             flush_seen;           // flush arrived during this refill

    logic [OFF-1:0]   pc_off;
    logic [IDX-1:0]   pc_idx;
    logic [TAG-1:0]   pc_tag;
    logic [IDX-1:0]   fill_idx;
    logic [TAG-1:0]   fill_tag;
    logic             hit_now;
    logic             accept;
    logic             last_beat;
    logic             unused_pc_bits;

    assign pc_off    = bus.pc[OFF+1:2];
    assign pc_idx    = bus.pc[OFF+IDX+1:OFF+2];
    assign pc_tag    = bus.pc[31:OFF+IDX+2];
    assign fill_idx  = line_addr[IDX-1:0];
    assign fill_tag  = line_addr[LA-1:IDX];

    // Byte offset within the word is irrelevant to a word-organised cache.
    assign unused_pc_bits = &{1'b0, bus.pc[1:0]};

    // A hit is only reported while idle, so a line never hits half-filled.
    assign hit_now   = (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign accept    = (state == REFILL) && bus.mem_valid;
    assign last_beat = accept && (beat == LAST_BEAT);

    assign bus.hit         = hit_now;
    assign bus.instruction = hit_now ? data_mem[pc_idx][pc_off] : 32'd0;
    assign bus.adder_out   = bus.pc + 32'd4;
    assign bus.mem_req     = (state == REFILL);
    assign bus.mem_addr    = (state == REFILL) ? {line_addr, beat, 2'b00} : 32'd0;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: a miss without flush starts a refill; the final beat ends it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!hit_now && !bus.flush) next_state = REFILL;
            REFILL:  if (last_beat)              next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control datapath: valid bits, refill address, beat counter, pending flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid      <= '0;
            line_addr  <= '0;
            beat       <= '0;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (!hit_now) begin
                        line_addr      <= bus.pc[31:OFF+2];
                        beat           <= '0;
                        flush_seen     <= 1'b0;
                        valid[pc_idx]  <= 1'b0;
                    end
                end
                REFILL: begin
                    // beat wraps back to zero exactly on the final beat
                    if (accept) begin
                        beat <= beat + OFF'(1);
                    end
                    if (bus.flush) begin
                        valid      <= '0;
                        flush_seen <= 1'b1;
                    end else if (last_beat && !flush_seen) begin
                        valid[fill_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage writes: each accepted beat fills one word, the last also writes the tag.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[fill_idx][beat] <= bus.mem_rdata;
        end
        if (last_beat) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch_ctrl
// Description : Self-checking bench for icache_fetch_ctrl. A line-level
//               behavioural cache model predicts every output each cycle;
//               directed sequences pin literal values, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_ctrl;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int OFF   = 2;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    icache_fetch_ctrl_if bus ();

    icache_fetch_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Behavioural model: lines tracked by full line number (address / line size).
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    logic [31:0] m_data  [LINES][WORDS];
    bit          m_busy;
    logic [31:0] m_fill_base;
    int          m_beats;
    bit          m_flushed;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> (OFF + 2)) & (LINES - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_busy    = 1'b0;
        m_beats   = 0;
        m_flushed = 1'b0;
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int i = idx_of(a);
        return !m_busy && m_valid[i] && (m_line[i] == (a >> (OFF + 2)));
    endfunction

    task automatic check_model();
        logic [31:0] a = bus.pc;
        bit h = model_hit(a);
        int i = idx_of(a);
        chk("hit", {31'd0, bus.hit}, {31'd0, h});
        chk("instruction", bus.instruction, h ? m_data[i][int'((a >> 2) & (WORDS - 1))] : 32'd0);
        chk("adder_out", bus.adder_out, a + 32'd4);
        chk("mem_req", {31'd0, bus.mem_req}, {31'd0, m_busy});
        if (m_busy) chk("mem_addr", bus.mem_addr, m_fill_base + 32'(4 * m_beats));
    endtask

    // Advance the model across one rising edge using the inputs held this cycle.
    task automatic model_step();
        logic [31:0] a = bus.pc;
        int li;
        if (!rstn) return;
        if (!m_busy) begin
            if (bus.flush) begin
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            end else if (!model_hit(a)) begin
                m_busy      = 1'b1;
                m_fill_base = a & ~32'(WORDS * 4 - 1);
                m_beats     = 0;
                m_flushed   = 1'b0;
                m_valid[idx_of(a)] = 1'b0;
            end
        end else begin
            if (bus.flush) begin
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
                m_flushed = 1'b1;
            end
            if (bus.mem_valid) begin
                li = idx_of(m_fill_base);
                m_data[li][m_beats] = bus.mem_rdata;
                m_beats++;
                if (m_beats == WORDS) begin
                    m_busy     = 1'b0;
                    m_beats    = 0;
                    m_line[li] = m_fill_base >> (OFF + 2);
                    if (!m_flushed) m_valid[li] = 1'b1;
                end
            end
        end
    endtask

    // Start of a cycle: drive inputs on the falling edge, then compare.
    task automatic drive(input logic rn, input logic [31:0] a, input logic fl,
                         input logic mv, input logic [31:0] rd);
        @(negedge clk);
        rstn          = rn;
        bus.pc        = a;
        bus.flush     = fl;
        bus.mem_valid = mv;
        bus.mem_rdata = rd;
        if (!rn) model_reset();
        #2;
        check_model();
    endtask

    // End of a cycle: the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    logic [31:0] pool [8];
    logic [31:0] cur_pc;

    initial begin
        pool = '{32'h100, 32'h500, 32'h108, 32'h300, 32'h1F0, 32'h2F4, 32'hFFFF_FFFC, 32'h40};
        rstn          = 1'b0;
        bus.pc        = 32'd0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'd0;
        model_reset();

        // Reset state
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("rst_hit", {31'd0, bus.hit}, 32'd0);
        chk("rst_instr", bus.instruction, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        tick();
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'd0); tick();

        // First fill of 0x100 with zero-wait memory
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("a_miss", {31'd0, bus.hit}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100, 1'b0, 1'b1, 32'hA0 + 32'(k));
            chk("a_req", {31'd0, bus.mem_req}, 32'd1);
            chk("a_addr", bus.mem_addr, 32'h100 + 32'(4 * k));
            tick();
        end
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("a_hit", {31'd0, bus.hit}, 32'd1);
        chk("a_instr", bus.instruction, 32'hA0);
        chk("a_adder", bus.adder_out, 32'h104);
        chk("a_req_drop", {31'd0, bus.mem_req}, 32'd0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 32'd0);
        chk("a2_hit", {31'd0, bus.hit}, 32'd1);
        chk("a2_instr", bus.instruction, 32'hA2);
        chk("a2_req", {31'd0, bus.mem_req}, 32'd0);
        tick();

        // Conflict miss on 0x500, memory valid every other cycle
        drive(1'b1, 32'h500, 1'b0, 1'b0, 32'd0); tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h500, 1'b0, k[0], 32'hB0 + 32'(k / 2));
            chk("b_req", {31'd0, bus.mem_req}, 32'd1);
            tick();
        end
        drive(1'b1, 32'h500, 1'b0, 1'b0, 32'd0);
        chk("b_hit", {31'd0, bus.hit}, 32'd1);
        chk("b_instr", bus.instruction, 32'hB0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("b_evicted", {31'd0, bus.hit}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100, 1'b0, 1'b1, 32'hA0 + 32'(k)); tick();
        end

        // Flush while hitting
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'd0);
        chk("c_hit_before", {31'd0, bus.hit}, 32'd1);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("c_hit_after", {31'd0, bus.hit}, 32'd0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'hA0);
        chk("c_req", {31'd0, bus.mem_req}, 32'd1);
        tick();

        // Reset on the second refill beat
        drive(1'b0, 32'h100, 1'b0, 1'b1, 32'hA1);
        chk("d_req_rst", {31'd0, bus.mem_req}, 32'd0);
        tick();
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'd0); tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("d_miss", {31'd0, bus.hit}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100, 1'b0, 1'b1, 32'hA0 + 32'(k));
            if (k == 0) chk("d_restart", bus.mem_addr, 32'h100);
            tick();
        end
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0);
        chk("d_hit", {31'd0, bus.hit}, 32'd1);
        tick();

        // Flush coinciding with the final beat
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'd0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h300, (k == 3), 1'b1, 32'hC0 + 32'(k)); tick();
        end
        drive(1'b1, 32'h300, 1'b0, 1'b0, 32'd0);
        chk("e_flush_last", {31'd0, bus.hit}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h300, 1'b0, 1'b1, 32'hC0 + 32'(k)); tick();
        end

        // Top of address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        chk("f_adder", bus.adder_out, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hD0 + 32'(k));
            chk("f_addr", bus.mem_addr, 32'hFFFF_FFF0 + 32'(4 * k));
            tick();
        end
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        chk("f_instr", bus.instruction, 32'hD3);
        tick();

        // Random traffic
        cur_pc = 32'h100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    cur_pc = pool[$urandom_range(0, 7)];
                    2:       cur_pc = (32'($urandom_range(0, 7)) << 8) |
                                      (32'($urandom_range(0, 15)) << 4) |
                                      (32'($urandom_range(0, 3)) << 2);
                    default: cur_pc = $urandom;
                endcase
            end
            drive(($urandom_range(0, 299) != 0), cur_pc, ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 2) != 0), $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
